fc_argmax: RTL and testbench
============================

// Module: fc_argmax
// PURPOSE
//  Sink for the serial class-score stream produced by the fully-connected layer (one signed
//  12-bit score per valid_in strobe, NUM_CLASS scores per frame, class 0 first).
//  Tracks the running maximum across a frame and emits the predicted digit index with a
//  one-cycle valid_out pulse. Sits at the tail of the MNIST CNN pipeline, feeding the
//  result display/UART.
// PARAMETERS
//  NUM_CLASS  10  scores per frame (classes 0..NUM_CLASS-1)
//  DATA_W     12  signed score width
//  CLASS_W    4   index width; must satisfy 2**CLASS_W >= NUM_CLASS
// PORTS
//  clk        in   1        rising-edge clock; the only clock
//  rst        in   1        asynchronous, active-low reset
//  clear      in   1        synchronous frame abort; discards any partial frame
//  valid_in   in   1        in_data carries a valid score this cycle
//  in_data    in   DATA_W   signed score, two's complement
//  valid_out  out  1        one-cycle pulse: decision/max_score updated
//  decision   out  CLASS_W  argmax index of the last completed frame
//  frame_busy out  1        high while a partial frame (1..NUM_CLASS-1 scores) is held
//  max_score  out  DATA_W   winning score (only with FC_ARGMAX_SCORE_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): valid_out=0, decision=0, frame_busy=0, max_score=0, cnt=0,
//    best=0, best_idx=0. Reset mid-frame drops the frame; no valid_out is produced.
//  - States: IDLE (cnt==0) and ACCUM (cnt 1..NUM_CLASS-1); frame_busy = (state==ACCUM).
//  - IDLE + valid_in: best<=in_data, best_idx<=0, cnt<=1, go to ACCUM.
//  - ACCUM + valid_in: if signed(in_data) > best then best<=in_data, best_idx<=cnt.
//    Ties keep the lower index (strict greater-than). cnt<=cnt+1.
//  - Last score (cnt==NUM_CLASS-1 and valid_in): the final compare is done combinationally;
//    decision<=winner, max_score<=winning score, valid_out<=1 on the next edge; cnt<=0; IDLE.
//  - Latency: valid_out rises on the clock edge that samples the last score, so it is high
//    during the cycle after that score is presented.
//  - NUM_CLASS==1: every valid_in completes a frame; decision=0.
//  - valid_out is high for exactly one cycle; decision/max_score hold until the next frame
//    completes.
//  - Gaps in valid_in stall accumulation indefinitely; there is no timeout.
//  - Back-to-back frames: a valid_in in the same cycle valid_out is high is class 0 of the
//    next frame and must be accepted (zero bubble).
//  - clear has priority over valid_in: cnt<=0, go to IDLE, the incoming score is dropped,
//    and decision/max_score are unchanged. clear on a last-score cycle suppresses valid_out.
//  - Arithmetic: signed DATA_W compare only; no widening and no saturation.
//    -2048 is a legal score.
// CONFIGURATION
//  FC_ARGMAX_SCORE_EN defined: the max_score port and register exist as described.
//  FC_ARGMAX_SCORE_EN undefined: the max_score port is absent; only best (the comparison
//  register) remains. decision timing is identical in both builds.
// STRUCTURE
//  Shared package (cnn_pkg): SCORE_W=12, NUM_CLASS=10, CLASS_W=4, and the state encoding
//  localparams ST_IDLE/ST_ACCUM.
//  One sub-module, argmax_cmp: combinational signed comparator returning the
//  {winner_score, winner_idx} of (best,best_idx) vs (in_data,cnt) under the tie rule;
//  it is reused for the final compare.
// TESTING
//  1 Scores 5,-3,100,7,0,0,0,0,0,99 -> valid_out 1 cycle after the 10th score,
//    decision=2, max_score=100.
//  2 All ten scores =-2048 -> decision=0 (tie keeps lowest), max_score=-2048.
//  3 Scores 0..8 = 10, class 9 = 11 -> decision=9; repeat with class 9 = 10 -> decision=0.
//  4 Two frames back-to-back with no gap (max at class 4, then class 7) -> two valid_out
//    pulses 10 cycles apart, decision 4 then 7.
//  5 Send 6 scores, pulse clear, then a full frame with max at class 3 -> one valid_out,
//    decision=3. Send 6 scores, assert rst=0, then a full frame -> same result.
//  6 Random valid_in gaps (0-5 idle cycles) over 1000 frames vs reference model ->
//    decision/max_score match and frame_busy is correct every cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the MNIST CNN tail: score/class widths and the
// argmax sink's state encoding.
package cnn_pkg;

  localparam int SCORE_W   = 12;
  localparam int NUM_CLASS = 10;
  localparam int CLASS_W   = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed comparator: picks (cand_score, cand_idx) only when it is
// strictly greater than the running best, so ties keep the lower index.
module argmax_cmp #(
  parameter int DATA_W  = cnn_pkg::SCORE_W,
  parameter int CLASS_W = cnn_pkg::CLASS_W
) (
  input  logic [DATA_W-1:0]  best_score,
  input  logic [CLASS_W-1:0] best_idx,
  input  logic [DATA_W-1:0]  cand_score,
  input  logic [CLASS_W-1:0] cand_idx,
  output logic [DATA_W-1:0]  win_score,
  output logic [CLASS_W-1:0] win_idx
);

  logic cand_wins;

  assign cand_wins = $signed(cand_score) > $signed(best_score);
  assign win_score = cand_wins ? cand_score : best_score;
  assign win_idx   = cand_wins ? cand_idx   : best_idx;

endmodule

// File: rtl/fc_argmax.sv
// Argmax sink for the serial FC class-score stream; emits the winning class
// index with a one-cycle valid_out pulse. FC_ARGMAX_SCORE_EN adds max_score.
module fc_argmax #(
  parameter int NUM_CLASS = cnn_pkg::NUM_CLASS,
  parameter int DATA_W    = cnn_pkg::SCORE_W,
  parameter int CLASS_W   = cnn_pkg::CLASS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  in_data,
  output logic               valid_out,
  output logic [CLASS_W-1:0] decision,
`ifdef FC_ARGMAX_SCORE_EN
  output logic               frame_busy,
  output logic [DATA_W-1:0]  max_score
`else
  output logic               frame_busy
`endif
);

  import cnn_pkg::ST_IDLE;
  import cnn_pkg::ST_ACCUM;

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASS - 1);

  logic               state, state_next;
  logic [CLASS_W-1:0] cnt, cnt_next;
  logic [DATA_W-1:0]  best;
  logic [CLASS_W-1:0] best_idx;
  logic [DATA_W-1:0]  cmp_score, win_score;
  logic [CLASS_W-1:0] cmp_idx, win_idx;
  logic               take, last_score;

  argmax_cmp #(
    .DATA_W  (DATA_W),
    .CLASS_W (CLASS_W)
  ) u_cmp (
    .best_score (best),
    .best_idx   (best_idx),
    .cand_score (in_data),
    .cand_idx   (cnt),
    .win_score  (cmp_score),
    .win_idx    (cmp_idx)
  );

  // Class 0 of a frame wins unconditionally; this also covers NUM_CLASS==1.
  assign win_score  = (state == ST_IDLE) ? in_data : cmp_score;
  assign win_idx    = (state == ST_IDLE) ? '0      : cmp_idx;
  assign take       = valid_in && !clear;
  assign last_score = take && (cnt == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (clear) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (valid_in) begin
      if (cnt == LAST_IDX) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        state_next = ST_ACCUM;
        cnt_next   = cnt + CLASS_W'(1);
      end
    end
  end

  always_comb begin
    frame_busy = (state == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      decision  <= '0;
      best      <= '0;
      best_idx  <= '0;
`ifdef FC_ARGMAX_SCORE_EN
      max_score <= '0;
`endif
    end else begin
      valid_out <= last_score;
      if (take) begin
        best     <= win_score;
        best_idx <= win_idx;
      end
      if (last_score) begin
        decision  <= win_idx;
`ifdef FC_ARGMAX_SCORE_EN
        max_score <= win_score;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: table vectors, hand-written multi-cycle
// sequences and a randomized run against a frame-level reference model.
module tb_fc_argmax;

  localparam int NUM_CLASS = 10;
  localparam int DATA_W    = 12;
  localparam int CLASS_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               valid_in;
  logic [DATA_W-1:0]  in_data;
  logic               valid_out;
  logic [CLASS_W-1:0] decision;
  logic               frame_busy;
`ifdef FC_ARGMAX_SCORE_EN
  logic [DATA_W-1:0]  max_score;
`endif

  fc_argmax #(
    .NUM_CLASS (NUM_CLASS),
    .DATA_W    (DATA_W),
    .CLASS_W   (CLASS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .valid_in   (valid_in),
    .in_data    (in_data),
    .valid_out  (valid_out),
    .decision   (decision),
`ifdef FC_ARGMAX_SCORE_EN
    .frame_busy (frame_busy),
    .max_score  (max_score)
`else
    .frame_busy (frame_busy)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulse_cyc[$];

  // Reference model: collects a frame's scores and takes the first maximum.
  int q[$];
  bit m_vo;
  int m_dec;
  int m_max;

  typedef struct {
    int sc[NUM_CLASS];
    int dec;
    int mx;
  } vec_t;

  vec_t tv[5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_vo  = 1'b0;
    m_dec = 0;
    m_max = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit clr);
    int bi;
    m_vo = 1'b0;
    if (clr) begin
      q.delete();
    end else if (v) begin
      q.push_back(d);
      if (q.size() == NUM_CLASS) begin
        bi = 0;
        for (int i = 1; i < NUM_CLASS; i++)
          if (q[i] > q[bi]) bi = i;
        m_dec = bi;
        m_max = q[bi];
        m_vo  = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check("valid_out", valid_out, m_vo);
    check("frame_busy", frame_busy, (q.size() != 0));
    check("decision", decision, m_dec);
`ifdef FC_ARGMAX_SCORE_EN
    check("max_score", $signed(max_score), m_max);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input bit v, input int d, input bit clr);
    valid_in = v;
    in_data  = d[DATA_W-1:0];
    clear    = clr;
    @(posedge clk);
    cyc++;
    model_edge(v, d, clr);
    #1;
    if (valid_out === 1'b1) pulse_cyc.push_back(cyc);
    check_outputs();
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_frame(input int sc[NUM_CLASS]);
    for (int i = 0; i < NUM_CLASS; i++) step(1'b1, sc[i], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("rst_valid_out", valid_out, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_decision", decision, 0);
`ifdef FC_ARGMAX_SCORE_EN
    check("rst_max_score", $signed(max_score), 0);
`endif
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fa[NUM_CLASS];
    int fb[NUM_CLASS];
    int fc[NUM_CLASS];
    int s;

    tv[0].sc = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};  tv[0].dec = 2; tv[0].mx = 100;
    tv[1].sc = '{default: -2048};                    tv[1].dec = 0; tv[1].mx = -2048;
    tv[2].sc = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 11}; tv[2].dec = 9; tv[2].mx = 11;
    tv[3].sc = '{default: 10};                       tv[3].dec = 0; tv[3].mx = 10;
    tv[4].sc = '{-2048, 2047, -2048, 2046, -1, 0, 1, -2048, 2047, 5};
    tv[4].dec = 1; tv[4].mx = 2047;

    fa = '{1, 2, 3, 4, 50, 5, 6, 7, 8, 9};
    fb = '{-5, -5, -5, -5, -5, -5, -5, 20, -5, 19};
    fc = '{0, 0, 0, 30, 0, 29, 0, 0, -30, 0};

    rst = 1'b0; clear = 1'b0; valid_in = 1'b0; in_data = '0;
    model_reset();
    #3;
    do_reset();
    step(1'b0, 0, 1'b0);

    // Table vectors: completed frame must pulse with the tabulated result.
    for (int k = 0; k < 5; k++) begin
      send_frame(tv[k].sc);
      check("tv_valid_out", valid_out, 1);
      check("tv_decision", decision, tv[k].dec);
`ifdef FC_ARGMAX_SCORE_EN
      check("tv_max_score", $signed(max_score), tv[k].mx);
`endif
      step(1'b0, 0, 1'b0);
    end

    // Back-to-back frames with no bubble.
    pulse_cyc.delete();
    send_frame(fa);
    check("bb_decision_a", decision, 4);
    send_frame(fb);
    check("bb_decision_b", decision, 7);
    check("bb_pulse_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2)
      check("bb_pulse_spacing", pulse_cyc[1] - pulse_cyc[0], 10);
    step(1'b0, 0, 1'b0);

    // Clear mid-frame (with a score present that must be dropped).
    pulse_cyc.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 500 + i, 1'b0);
    step(1'b1, 1000, 1'b1);
    check("clr_decision_held", decision, 7);
    send_frame(fc);
    check("clr_pulse_count", pulse_cyc.size(), 1);
    check("clr_decision", decision, 3);

    // Clear on the last-score cycle suppresses the pulse.
    pulse_cyc.delete();
    for (int i = 0; i < NUM_CLASS - 1; i++) step(1'b1, 900, 1'b0);
    step(1'b1, 901, 1'b1);
    step(1'b0, 0, 1'b0);
    check("clr_last_pulse_count", pulse_cyc.size(), 0);
    check("clr_last_decision", decision, 3);

    // Async reset mid-frame drops the frame.
    pulse_cyc.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 700, 1'b0);
    do_reset();
    step(1'b0, 0, 1'b0);
    send_frame(fc);
    check("rst_pulse_count", pulse_cyc.size(), 1);
    check("rst_frame_decision", decision, 3);

    // Randomized frames with idle gaps and rare clears.
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        repeat ($urandom_range(0, 5)) step(1'b0, 0, ($urandom_range(0, 199) == 0));
        if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 4)) - 2;
        else s = int'($urandom_range(0, 4095)) - 2048;
        step(1'b1, s, 1'b0);
      end
    end
    step(1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
